cvxif_issue_arbiter: RTL and testbench

- Shares the single CV-X-IF coprocessor port of the 64-bit core configuration between NrReq issue requesters, for example the scalar issue stage and a replay/debug path.
- Arbitrates the issue channel round-robin and allocates a transaction ID from a free pool.
- Records which requester owns each ID and routes coprocessor results back to that requester.
- Handles pipeline flushes by discarding results of killed transactions.

---
 rtl/cvxif_issue_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cvxif_issue_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_issue_arbiter.sv
// ---------------------------------------------------------------------------
// cvxif_issue_arbiter
//
// Shares one CV-X-IF coprocessor port between NrReq issue requesters.
// The issue channel is arbitrated round-robin, and each accepted instruction
// receives a transaction ID from a small free pool. The owner of each ID is
// recorded so that coprocessor results can be steered back to the requester
// that issued them. A flush marks every outstanding ID as killed, so its
// result is silently drained when it arrives.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             kill all outstanding transactions, block issue
//   req_valid_i         per-requester issue valid
//   req_instr_i         32-bit instruction per requester (packed)
//   req_rs_i            {rs2,rs1} operands per requester (packed)
//   req_ready_o         issue handshake done for that requester
//   req_accept_o        coprocessor accept flag for that handshake
//   x_issue_*           issue channel towards the coprocessor
//   x_result_*          result channel from the coprocessor
//   res_valid_o         result valid, one-hot on the owning requester
//   res_data_o          shared result data bus (zero when idle)
//   res_ready_i         per-requester result ready
//   err_o               result arrived for an unallocated ID
// ---------------------------------------------------------------------------
module cvxif_issue_arbiter #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned NrReq = 2,
   parameter int unsigned NrIds = 4,
   parameter int unsigned IdW   = ($clog2(NrIds) > 1) ? $clog2(NrIds) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic [NrReq-1:0]          req_valid_i,
   input  logic [NrReq*32-1:0]       req_instr_i,
   input  logic [NrReq*2*XLEN-1:0]   req_rs_i,
   output logic [NrReq-1:0]          req_ready_o,
   output logic                      req_accept_o,
   output logic                      x_issue_valid_o,
   input  logic                      x_issue_ready_i,
   input  logic                      x_issue_accept_i,
   output logic [31:0]               x_issue_instr_o,
   output logic [2*XLEN-1:0]         x_issue_rs_o,
   output logic [IdW-1:0]            x_issue_id_o,
   input  logic                      x_result_valid_i,
   input  logic [IdW-1:0]            x_result_id_i,
   input  logic [XLEN-1:0]           x_result_data_i,
   output logic                      x_result_ready_o,
   output logic [NrReq-1:0]          res_valid_o,
   output logic [XLEN-1:0]           res_data_o,
   input  logic [NrReq-1:0]          res_ready_i,
   output logic                      err_o
);

   localparam int unsigned OwnW = ($clog2(NrReq) > 1) ? $clog2(NrReq) : 1;

   logic [NrIds-1:0] busy_q;
   logic [NrIds-1:0] killed_q;
   logic [OwnW-1:0]  owner_q [NrIds];
   logic [OwnW-1:0]  rr_ptr_q;
   logic             lock_q;
   logic [OwnW-1:0]  lock_idx_q;
   logic [IdW-1:0]   lock_id_q;

   logic             free_found;
   logic [IdW-1:0]   free_id;
   logic             grant_found;
   logic [OwnW-1:0]  grant_idx;
   logic [OwnW-1:0]  cand;
   logic [IdW-1:0]   issue_id;
   logic             issue_hs;

   logic             res_busy;
   logic             res_killed;
   logic [OwnW-1:0]  res_owner;
   logic             res_hs;

   // Lowest free ID, looked up from registered state only, so an ID freed
   // this cycle can not be handed out before the next cycle.
   always_comb begin
      free_found = 1'b0;
      free_id    = '0;
      for (int i = int'(NrIds) - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_found = 1'b1;
            free_id    = IdW'(i);
         end
      end
   end

   // Round-robin grant starting at rr_ptr. Scanning from the far end and
   // overwriting leaves the nearest valid requester as the winner. While a
   // stalled issue is locked, the locked requester keeps the grant.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      if (lock_q) begin
         grant_found = 1'b1;
         grant_idx   = lock_idx_q;
      end else begin
         for (int i = int'(NrReq) - 1; i >= 0; i--) begin
            cand = OwnW'((int'(rr_ptr_q) + i) % int'(NrReq));
            if (req_valid_i[cand]) begin
               grant_found = 1'b1;
               grant_idx   = cand;
            end
         end
      end
   end

   // Issue channel. A locked issue reuses the ID captured when it stalled,
   // because a result freeing a lower ID must not change the offered ID.
   always_comb begin
      issue_id        = lock_q ? lock_id_q : free_id;
      x_issue_valid_o = (lock_q | (grant_found & free_found)) & ~flush_i;
      x_issue_instr_o = req_instr_i[int'(grant_idx)*32 +: 32];
      x_issue_rs_o    = req_rs_i[int'(grant_idx)*2*int'(XLEN) +: 2*XLEN];
      x_issue_id_o    = issue_id;
      issue_hs        = x_issue_valid_o & x_issue_ready_i;
      req_ready_o     = '0;
      if (issue_hs) begin
         req_ready_o[grant_idx] = 1'b1;
      end
      req_accept_o    = issue_hs & x_issue_accept_i;
   end

   // Result steering. Live results wait for their owner; killed results and
   // results for unallocated IDs are drained immediately.
   always_comb begin
      res_busy         = busy_q[x_result_id_i];
      res_killed       = killed_q[x_result_id_i];
      res_owner        = owner_q[x_result_id_i];
      res_valid_o      = '0;
      res_data_o       = '0;
      x_result_ready_o = 1'b0;
      err_o            = 1'b0;
      if (x_result_valid_i) begin
         if (res_busy && !res_killed) begin
            res_valid_o[res_owner] = 1'b1;
            res_data_o             = x_result_data_i;
            x_result_ready_o       = res_ready_i[res_owner];
         end else if (res_busy) begin
            x_result_ready_o = 1'b1;
         end else begin
            x_result_ready_o = 1'b1;
            err_o            = 1'b1;
         end
      end
      res_hs = x_result_valid_i & x_result_ready_o & res_busy;
   end

   // State update. The flush kill is applied first so that a result retired
   // in the same cycle still frees its ID cleanly. Issue is blocked during a
   // flush and never targets a busy ID, so the writes below never collide.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q     <= '0;
         killed_q   <= '0;
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         lock_id_q  <= '0;
         for (int i = 0; i < int'(NrIds); i++) begin
            owner_q[i] <= '0;
         end
      end else begin
         if (flush_i) begin
            killed_q <= killed_q | busy_q;
         end
         if (res_hs) begin
            busy_q[x_result_id_i]   <= 1'b0;
            killed_q[x_result_id_i] <= 1'b0;
         end
         if (issue_hs && x_issue_accept_i) begin
            busy_q[issue_id]   <= 1'b1;
            killed_q[issue_id] <= 1'b0;
            owner_q[issue_id]  <= grant_idx;
         end
         if (issue_hs) begin
            rr_ptr_q <= (grant_idx == OwnW'(NrReq - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (flush_i || issue_hs) begin
            lock_q <= 1'b0;
         end else if (x_issue_valid_o && !x_issue_ready_i) begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant_idx;
            lock_id_q  <= issue_id;
         end
      end
   end

endmodule

// File: tb/tb_cvxif_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cvxif_issue_arbiter
//
// Directed testbench for cvxif_issue_arbiter with the default configuration
// (XLEN=64, NrReq=2, NrIds=4). Each scenario task drives inputs just after a
// rising edge and compares outputs mid-cycle against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cvxif_issue_arbiter;

   localparam int XLEN  = 64;
   localparam int NrReq = 2;
   localparam int NrIds = 4;
   localparam int IdW   = 2;

   localparam logic [31:0]       INSTR0 = 32'h0000_A00B;
   localparam logic [31:0]       INSTR1 = 32'h0000_B00B;
   localparam logic [2*XLEN-1:0] RS0    = {64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
   localparam logic [2*XLEN-1:0] RS1    = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003};

   logic                    clk;
   logic                    rst;
   logic                    flush;
   logic [NrReq-1:0]        req_valid;
   logic [NrReq*32-1:0]     req_instr;
   logic [NrReq*2*XLEN-1:0] req_rs;
   logic [NrReq-1:0]        req_ready;
   logic                    req_accept;
   logic                    x_issue_valid;
   logic                    x_issue_ready;
   logic                    x_issue_accept;
   logic [31:0]             x_issue_instr;
   logic [2*XLEN-1:0]       x_issue_rs;
   logic [IdW-1:0]          x_issue_id;
   logic                    x_result_valid;
   logic [IdW-1:0]          x_result_id;
   logic [XLEN-1:0]         x_result_data;
   logic                    x_result_ready;
   logic [NrReq-1:0]        res_valid;
   logic [XLEN-1:0]         res_data;
   logic [NrReq-1:0]        res_ready;
   logic                    err;

   int n_compared;
   int n_mismatched;

   cvxif_issue_arbiter #(
      .XLEN  (XLEN),
      .NrReq (NrReq),
      .NrIds (NrIds)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .flush_i          (flush),
      .req_valid_i      (req_valid),
      .req_instr_i      (req_instr),
      .req_rs_i         (req_rs),
      .req_ready_o      (req_ready),
      .req_accept_o     (req_accept),
      .x_issue_valid_o  (x_issue_valid),
      .x_issue_ready_i  (x_issue_ready),
      .x_issue_accept_i (x_issue_accept),
      .x_issue_instr_o  (x_issue_instr),
      .x_issue_rs_o     (x_issue_rs),
      .x_issue_id_o     (x_issue_id),
      .x_result_valid_i (x_result_valid),
      .x_result_id_i    (x_result_id),
      .x_result_data_i  (x_result_data),
      .x_result_ready_o (x_result_ready),
      .res_valid_o      (res_valid),
      .res_data_o       (res_data),
      .res_ready_i      (res_ready),
      .err_o            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guards against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      flush          = 1'b0;
      req_valid      = '0;
      x_issue_ready  = 1'b0;
      x_issue_accept = 1'b0;
      x_result_valid = 1'b0;
      x_result_id    = '0;
      x_result_data  = '0;
      res_ready      = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reset state, and reset clearing previously allocated IDs.
   task automatic test_reset();
      do_reset();
      #2;
      n_compared++; if (x_issue_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_issue_valid: got %b want 0", x_issue_valid); end
      n_compared++; if (req_ready !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_req_ready: got %b want 00", req_ready); end
      n_compared++; if (req_accept !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_req_accept: got %b want 0", req_accept); end
      n_compared++; if (res_valid !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_res_valid: got %b want 00", res_valid); end
      n_compared++; if (res_data !== 64'd0) begin n_mismatched++; $display("[TB] FAIL reset_res_data: got %h want 0", res_data); end
      n_compared++; if (x_result_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_result_ready: got %b want 0", x_result_ready); end
      n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_err: got %b want 0", err); end
      req_valid      = 2'b01;
      x_issue_ready  = 1'b1;
      x_issue_accept = 1'b1;
      tick();
      tick();
      do_reset();
      req_valid      = 2'b01;
      x_issue_ready  = 1'b1;
      x_issue_accept = 1'b1;
      #2;
      n_compared++; if (x_issue_id !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset_frees_ids: got id %0d want 0", x_issue_id); end
   endtask

   // Both requesters always valid: grants alternate and IDs fill up.
   task automatic test_round_robin();
      logic [1:0]  exp_rdy;
      logic [31:0] exp_instr;
      logic [1:0]  exp_id;
      do_reset();
      req_valid      = 2'b11;
      x_issue_ready  = 1'b1;
      x_issue_accept = 1'b1;
      for (int k = 0; k < 4; k++) begin
         exp_rdy   = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_instr = (k % 2 == 0) ? INSTR0 : INSTR1;
         exp_id    = k[1:0];
         #2;
         n_compared++; if (x_issue_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rr_valid[%0d]: got %b want 1", k, x_issue_valid); end
         n_compared++; if (req_ready !== exp_rdy) begin n_mismatched++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy); end
         n_compared++; if (x_issue_instr !== exp_instr) begin n_mismatched++; $display("[TB] FAIL rr_instr[%0d]: got %h want %h", k, x_issue_instr, exp_instr); end
         n_compared++; if (x_issue_id !== exp_id) begin n_mismatched++; $display("[TB] FAIL rr_id[%0d]: got %0d want %0d", k, x_issue_id, exp_id); end
         n_compared++; if (req_accept !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rr_accept[%0d]: got %b want 1", k, req_accept); end
         tick();
      end
      #2;
      n_compared++; if (x_issue_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rr_full_valid: got %b want 0", x_issue_valid); end
      n_compared++; if (req_ready !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rr_full_ready: got %b want 00", req_ready); end
   endtask

   // Stalled issue stays locked to requester 1 even once requester 0 joins.
   task automatic test_lock();
      do_reset();
      req_valid      = 2'b10;
      x_issue_ready  = 1'b0;
      x_issue_accept = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) req_valid = 2'b11;
         #2;
         n_compared++; if (x_issue_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lock_valid[%0d]: got %b want 1", k, x_issue_valid); end
         n_compared++; if (x_issue_instr !== INSTR1) begin n_mismatched++; $display("[TB] FAIL lock_instr[%0d]: got %h want %h", k, x_issue_instr, INSTR1); end
         n_compared++; if (x_issue_rs !== RS1) begin n_mismatched++; $display("[TB] FAIL lock_rs[%0d]: got %h want %h", k, x_issue_rs, RS1); end
         n_compared++; if (x_issue_id !== 2'd0) begin n_mismatched++; $display("[TB] FAIL lock_id[%0d]: got %0d want 0", k, x_issue_id); end
         n_compared++; if (req_ready !== 2'b00) begin n_mismatched++; $display("[TB] FAIL lock_ready[%0d]: got %b want 00", k, req_ready); end
         tick();
      end
      x_issue_ready = 1'b1;
      #2;
      n_compared++; if (req_ready !== 2'b10) begin n_mismatched++; $display("[TB] FAIL lock_release_ready: got %b want 10", req_ready); end
      tick();
      #2;
      n_compared++; if (req_ready !== 2'b01) begin n_mismatched++; $display("[TB] FAIL lock_next_grant: got %b want 01", req_ready); end
      n_compared++; if (x_issue_id !== 2'd1) begin n_mismatched++; $display("[TB] FAIL lock_next_id: got %0d want 1", x_issue_id); end
      n_compared++; if (x_issue_rs !== RS0) begin n_mismatched++; $display("[TB] FAIL lock_next_rs: got %h want %h", x_issue_rs, RS0); end
      tick();
   endtask

   // A rejected issue completes the handshake but allocates no ID.
   task automatic test_reject();
      do_reset();
      req_valid      = 2'b01;
      x_issue_ready  = 1'b1;
      x_issue_accept = 1'b0;
      #2;
      n_compared++; if (req_ready !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rej_ready: got %b want 01", req_ready); end
      n_compared++; if (req_accept !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rej_accept: got %b want 0", req_accept); end
      tick();
      x_issue_accept = 1'b1;
      #2;
      n_compared++; if (x_issue_id !== 2'd0) begin n_mismatched++; $display("[TB] FAIL rej_reuse_id: got %0d want 0", x_issue_id); end
      n_compared++; if (req_accept !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rej_then_accept: got %b want 1", req_accept); end
      tick();
   endtask

   // Result for ID 2 owned by requester 1, with backpressure and reuse.
   task automatic test_result_route();
      do_reset();
      req_valid      = 2'b10;
      x_issue_ready  = 1'b1;
      x_issue_accept = 1'b1;
      tick();
      tick();
      tick();
      req_valid      = 2'b00;
      x_result_valid = 1'b1;
      x_result_id    = 2'd2;
      x_result_data  = 64'hDEAD_BEEF;
      res_ready      = 2'b00;
      #2;
      n_compared++; if (res_valid !== 2'b10) begin n_mismatched++; $display("[TB] FAIL res_valid: got %b want 10", res_valid); end
      n_compared++; if (res_data !== 64'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL res_data: got %h want deadbeef", res_data); end
      n_compared++; if (x_result_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL res_backpressure: got %b want 0", x_result_ready); end
      n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL res_err: got %b want 0", err); end
      tick();
      #2;
      n_compared++; if (res_valid !== 2'b10) begin n_mismatched++; $display("[TB] FAIL res_held: got %b want 10", res_valid); end
      res_ready = 2'b10;
      req_valid = 2'b01;
      #1;
      n_compared++; if (x_result_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL res_ready: got %b want 1", x_result_ready); end
      n_compared++; if (x_issue_id !== 2'd3) begin n_mismatched++; $display("[TB] FAIL res_same_cycle_id: got %0d want 3", x_issue_id); end
      tick();
      x_result_valid = 1'b0;
      res_ready      = 2'b00;
      #2;
      n_compared++; if (res_data !== 64'd0) begin n_mismatched++; $display("[TB] FAIL res_idle_data: got %h want 0", res_data); end
      n_compared++; if (x_issue_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL res_reuse_valid: got %b want 1", x_issue_valid); end
      n_compared++; if (x_issue_id !== 2'd2) begin n_mismatched++; $display("[TB] FAIL res_reuse_id: got %0d want 2", x_issue_id); end
      tick();
   endtask

   // Flush kills IDs 0 and 1; their results drain silently and free them.
   task automatic test_flush();
      do_reset();
      req_valid      = 2'b11;
      x_issue_ready  = 1'b1;
      x_issue_accept = 1'b1;
      tick();
      tick();
      flush = 1'b1;
      #2;
      n_compared++; if (x_issue_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_blocks_issue: got %b want 0", x_issue_valid); end
      n_compared++; if (req_ready !== 2'b00) begin n_mismatched++; $display("[TB] FAIL flush_ready: got %b want 00", req_ready); end
      tick();
      flush     = 1'b0;
      req_valid = 2'b00;
      for (int k = 0; k < 2; k++) begin
         x_result_valid = 1'b1;
         x_result_id    = k[1:0];
         x_result_data  = 64'h0BAD_0000 + 64'(k);
         #2;
         n_compared++; if (res_valid !== 2'b00) begin n_mismatched++; $display("[TB] FAIL flush_res_valid[%0d]: got %b want 00", k, res_valid); end
         n_compared++; if (x_result_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_res_ready[%0d]: got %b want 1", k, x_result_ready); end
         n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_err[%0d]: got %b want 0", k, err); end
         tick();
      end
      x_result_valid = 1'b0;
      req_valid      = 2'b01;
      #2;
      n_compared++; if (x_issue_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL flush_reissue_valid: got %b want 1", x_issue_valid); end
      n_compared++; if (x_issue_id !== 2'd0) begin n_mismatched++; $display("[TB] FAIL flush_reissue_id: got %0d want 0", x_issue_id); end
      tick();
   endtask

   // Result for an idle ID is dropped with a one-cycle error pulse.
   task automatic test_bad_id();
      do_reset();
      x_result_valid = 1'b1;
      x_result_id    = 2'd3;
      x_result_data  = 64'h1234;
      res_ready      = 2'b11;
      #2;
      n_compared++; if (x_result_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bad_ready: got %b want 1", x_result_ready); end
      n_compared++; if (err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bad_err: got %b want 1", err); end
      n_compared++; if (res_valid !== 2'b00) begin n_mismatched++; $display("[TB] FAIL bad_res_valid: got %b want 00", res_valid); end
      tick();
      x_result_valid = 1'b0;
      res_ready      = 2'b00;
      req_valid      = 2'b01;
      x_issue_ready  = 1'b1;
      x_issue_accept = 1'b1;
      #2;
      n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bad_err_pulse: got %b want 0", err); end
      n_compared++; if (x_issue_id !== 2'd0) begin n_mismatched++; $display("[TB] FAIL bad_busy_kept: got id %0d want 0", x_issue_id); end
      tick();
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      req_instr    = {INSTR1, INSTR0};
      req_rs       = {RS1, RS0};
      test_reset();
      test_round_robin();
      test_lock();
      test_reject();
      test_result_route();
      test_flush();
      test_bad_id();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
